// File: rtl/alu_wide_seq.sv
// Multi-byte arithmetic sequencer for an external 8-bit ALU.
// Accepts an NBYTES-wide operation and feeds the ALU one byte per clock.
// Chains the carry/borrow between bytes, then returns the wide result.
module alu_wide_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic [2:0]            in_op,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_c,
    output logic                  out_carry,
    output logic                  out_zero,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_carry,
    output logic [3:0]            alu_op,
    input  logic [7:0]            alu_c,
    input  logic                  alu_carry_out,
    input  logic                  alu_zero
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
        OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7
    } op_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    op_t             op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            zacc_q, zacc_d;
    logic [W-1:0]    res_q, res_d;
    logic [CW-1:0]   idx;

    // Logic ops never produce or consume a carry.
    function automatic logic is_logic(input op_t op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_NOT);
    endfunction

    // Translate the wide opcode to the byte ALU's opcode.
    function automatic logic [3:0] alu_code(input op_t op);
        case (op)
            OP_ADD:  return 4'd1;
            OP_SUB:  return 4'd3;
            OP_AND:  return 4'd5;
            OP_OR:   return 4'd4;
            OP_XOR:  return 4'd7;
            OP_NOT:  return 4'd6;
            OP_SHL:  return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    // Next-state logic: acceptance, per-byte ALU drive/collect, result hold.
    always_comb begin
        // NOTE: every variable gets a default before the case so no branch can infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        res_d     = res_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_carry = 1'b0;
        alu_op    = '0;
        // SHR must see the top byte first so the shift-in bit ripples downward.
        idx = (op_q == OP_SHR) ? (CW'(NBYTES - 1) - cnt_q) : cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = op_t'(in_op);
                    cnt_d   = '0;
                    carry_d = is_logic(op_t'(in_op)) ? 1'b0 : in_cin;
                    zacc_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx == CW'(i)) begin
                        alu_a            = a_q[8*i +: 8];
                        alu_b            = b_q[8*i +: 8];
                        res_d[8*i +: 8]  = alu_c;
                    end
                end
                alu_carry = carry_q;
                alu_op    = alu_code(op_q);
                carry_d   = is_logic(op_q) ? 1'b0 : alu_carry_out;
                zacc_d    = zacc_q & alu_zero;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(NBYTES - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign out_c     = res_q;
    assign out_carry = carry_q;
    assign out_zero  = zacc_q;

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Multi-byte arithmetic sequencer that sits directly upstream and downstream of the 8-bit combinational ALU. It accepts an NBYTES-wide operation over a valid/ready handshake and drives the ALU one byte per clock. It chains the ALU carry/borrow between bytes, collects each byte of result, and returns a wide result with carry and zero flags over a second valid/ready handshake. The ALU itself is instantiated outside this block and connected through the `alu_*` ports.

## Interface

Parameters:
- NBYTES, 4: operand width in bytes; must be ≥ 2. Word width W = 8*NBYTES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_a  input  W  operand A.
- in_b  input  W  operand B; ignored for NOT, SHL, SHR.
- in_op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR.
- in_cin  input  1  initial carry/borrow/shift-in bit; ignored for logic ops.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- out_c  output  W  result.
- out_carry  output  1  final carry out. For ADD this is the carry; for SUB the borrow; for SHL/SHR the bit shifted out. Always 0 for logic ops.
- out_zero  output  1  out_c == 0.
- alu_a, alu_b  output  8  current byte to the ALU.
- alu_carry  output  1  carry into the ALU.
- alu_op  output  4  ALU opcode.
- alu_c  input  8  ALU result byte.
- alu_carry_out  input  1  ALU bit 8.
- alu_zero  input  1  ALU zero flag.

## Operation

- States: IDLE, RUN, DONE.
- **IDLE:**
  - Drives in_ready = 1.
  - On in_valid && in_ready:
    - latch in_a, in_b, in_op, in_cin;
    - clear byte counter to 0;
    - set chained-carry register to in_cin for arithmetic and shift ops, 0 for logic ops;
    - set zero-accumulator to 1;
    - go to RUN.
- **RUN:** one byte per cycle, NBYTES cycles.
  - Byte order:
    - SHR runs MSB first (byte NBYTES-1 down to 0).
    - All other ops run LSB first (byte 0 up).
  - alu_op mapping:
    - ADD→1 (adc)
    - SUB→3 (sbc)
    - AND→5
    - OR→4
    - XOR→7
    - NOT→6
    - SHL→14 (shiftlc)
    - SHR→15 (shiftrc)
  - alu_a and alu_b carry the selected byte of the latched operands; alu_carry carries the chained-carry register.
  - At each edge:
    - store alu_c into the matching result byte;
    - chained-carry ← alu_carry_out (forced 0 for logic ops);
    - zero-accumulator &= alu_zero.
  - After the final byte, go to DONE.
- **DONE:**
  - out_valid = 1.
  - out_c, out_carry (the last chained carry) and out_zero (the zero-accumulator) are stable.
  - On out_ready, go to IDLE.
- **Outside RUN:** alu_* outputs are 0 (alu_op = 0).
- **Arithmetic:**
  - ADD computes A+B+cin mod 2^W.
  - SUB computes A−B−cin mod 2^W; out_carry = 1 iff A < B+cin (unsigned).
  - SHL result is {A[W-2:0], cin}; out_carry = A[W-1].
  - SHR result is {cin, A[W-1:1]}; out_carry = A[0].
  - NOT result is ~A.
- **Reset:** synchronous, takes priority over every other event.
  - State → IDLE.
  - out_valid, out_c, out_carry, out_zero → 0.
  - Latched operands, counter and carry → 0.
  - Reset during RUN or DONE aborts the operation with no result emitted.
- **Simultaneous events:** in_valid arriving in RUN or DONE is ignored, because in_ready = 0. The requester must hold it.

## Timing

- Acceptance edge E0.
- RUN processes bytes at edges E1..E_NBYTES.
- out_valid rises after edge E_NBYTES: NBYTES cycles of latency from acceptance to result visible.
- The result is held indefinitely while out_ready = 0.
- The out_valid && out_ready edge returns to IDLE:
  - out_valid falls after that edge;
  - in_ready rises after that edge.
- Throughput: one operation per NBYTES+2 cycles at best.
- in_ready is decoded from state and is 0 during the reset cycle.
- There is one combinational path per cycle, register → ALU → register; the block adds no combinational path from in_* to out_*.

## Test plan

All cases use NBYTES = 4 with the real ALU attached.

1. **ADD with carry ripple:** ADD 0x00FFFFFF + 0x00000001, cin=0 → out_c=0x01000000, out_carry=0, out_zero=0. out_valid is high exactly 4 edges after acceptance.
2. **SUB borrow and zero:**
   - SUB 0x00000000 − 0x00000001, cin=0 → 0xFFFFFFFF, out_carry=1, out_zero=0.
   - SUB 0x12345678 − 0x12345678 → 0x00000000, out_carry=0, out_zero=1.
3. **Shifts:**
   - SHL 0x80000001, cin=1 → 0x00000003, out_carry=1.
   - SHR 0x80000001, cin=0 → 0x40000000, out_carry=1.
4. **Logic ops:**
   - XOR 0xA5A5A5A5 ^ 0xA5A5A5A5 → 0, out_zero=1, out_carry=0.
   - NOT 0x0F0F0000 → 0xF0F0FFFF, out_carry=0, even when cin=1.
5. **Backpressure:** hold out_ready=0 for 5 cycles in DONE → out_valid and out_c are stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready → next cycle in_ready=1 and the second request is accepted.
6. **Reset mid-op:** assert rst while processing byte 2 of an ADD → after the edge, in_ready=1, out_valid=0, out_c=0, and no result is ever emitted for the aborted request.
